// File: rtl/feature_reducer.sv
// Pipelined reduction of NUM_CH signed features into one saturated DATA_W result.
// Selectable per sample: sum, alternating-sign sum, signed max, or mean (floor shift).
module feature_reducer #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_features_valid,
  input  logic signed [DATA_W-1:0] i_features_in [NUM_CH],
  input  logic [1:0]               i_mode,
  input  logic                     i_sat_clr,
  output logic                     o_feature_valid,
  output logic signed [DATA_W-1:0] o_feature_out,
  output logic                     o_sat_sticky
);

  localparam int unsigned LVL   = $clog2(NUM_CH);
  localparam int unsigned ACC_W = DATA_W + LVL;

  localparam logic [1:0] MODE_ALT  = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;
  localparam logic [1:0] MODE_MEAN = 2'd3;

  // Number of live nodes on tree level lvl (level 0 holds the leaves).
  function automatic int unsigned f_cnt(input int unsigned lvl);
    return (NUM_CH + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  // Start index of tree level lvl inside the flat node array.
  function automatic int unsigned f_off(input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < lvl; k++) off += f_cnt(k);
    return off;
  endfunction

  localparam int unsigned N_NODE = f_off(LVL + 1);

  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(OUT_MIN);

  logic signed [ACC_W-1:0]  r_tree     [N_NODE];
  logic signed [ACC_W-1:0]  w_tree_nxt [N_NODE];
  logic [LVL:0]             r_valid;
  logic [LVL:0][1:0]        r_mode;

  logic signed [ACC_W-1:0]  w_root;
  logic signed [ACC_W-1:0]  w_scaled;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic signed [DATA_W-1:0] w_clamp;

  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out;
  logic                     r_sat_sticky;

  // Leaves: widen to ACC_W first so negating the most negative input stays exact.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_leaf
    if ((i % 2) == 1) begin : g_odd
      assign w_tree_nxt[i] = (i_mode == MODE_ALT) ? -ACC_W'(i_features_in[i])
                                                  :  ACC_W'(i_features_in[i]);
    end else begin : g_even
      assign w_tree_nxt[i] = ACC_W'(i_features_in[i]);
    end
  end

  // Tree levels: pairs combine under that level's mode, an odd leftover passes through.
  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    for (genvar j = 0; j < f_cnt(l); j++) begin : g_node
      localparam int unsigned SRC = f_off(l - 1) + 2 * j;
      localparam int unsigned DST = f_off(l) + j;
      if ((2 * j + 1) < f_cnt(l - 1)) begin : g_pair
        assign w_tree_nxt[DST] =
          (r_mode[l-1] == MODE_MAX) ? ((r_tree[SRC] > r_tree[SRC+1]) ? r_tree[SRC] : r_tree[SRC+1])
                                    : (r_tree[SRC] + r_tree[SRC+1]);
      end else begin : g_pass
        assign w_tree_nxt[DST] = r_tree[SRC];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[LVL-1:0], i_features_valid};
    end
  end

  // Data path carries no reset; only the valid chain qualifies it.
  always_ff @(posedge i_clk) begin
    r_mode <= {r_mode[LVL-1:0], i_mode};
    r_tree <= w_tree_nxt;
  end

  assign w_root   = r_tree[N_NODE-1];
  assign w_scaled = (r_mode[LVL] == MODE_MEAN) ? (w_root >>> LVL) : w_root;
  assign w_sat_hi = (w_scaled > SAT_MAX);
  assign w_sat_lo = (w_scaled < SAT_MIN);
  assign w_clamp  = w_sat_hi ? OUT_MAX : (w_sat_lo ? OUT_MIN : w_scaled[DATA_W-1:0]);

  // A new saturation outranks a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_sat_sticky <= 1'b0;
    end else begin
      r_out_valid  <= r_valid[LVL];
      if (r_valid[LVL]) r_out <= w_clamp;
      r_sat_sticky <= (r_valid[LVL] & (w_sat_hi | w_sat_lo)) | (r_sat_sticky & ~i_sat_clr);
    end
  end

  assign o_feature_valid = r_out_valid;
  assign o_feature_out   = r_out;
  assign o_sat_sticky    = r_sat_sticky;

endmodule

// File: tb/tb_feature_reducer.sv
// Self-checking bench for feature_reducer: directed vectors plus randomized traffic
// compared cycle by cycle against a latency-scheduled arithmetic reference model.
module tb_feature_reducer;

  localparam int NUM_CH = 6;
  localparam int DATA_W = 8;
  localparam int LVL    = 3;
  localparam int LAT    = LVL + 2;

  typedef logic signed [DATA_W-1:0] vec_t [NUM_CH];
  typedef struct {
    int slot;
    int val;
    bit sat;
  } pend_t;

  logic                     clk = 1'b0;
  logic                     i_rst;
  logic                     i_features_valid;
  vec_t                     i_features_in;
  logic [1:0]               i_mode;
  logic                     i_sat_clr;
  logic                     o_feature_valid;
  logic signed [DATA_W-1:0] o_feature_out;
  logic                     o_sat_sticky;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_edge   = 0;
  pend_t q[$];
  int    m_valid  = 0;
  int    m_out    = 0;
  int    m_sticky = 0;
  int    obs_val[$];
  int    obs_edge[$];

  always #5 clk = ~clk;

  feature_reducer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_features_valid (i_features_valid),
    .i_features_in    (i_features_in),
    .i_mode           (i_mode),
    .i_sat_clr        (i_sat_clr),
    .o_feature_valid  (o_feature_valid),
    .o_feature_out    (o_feature_out),
    .o_sat_sticky     (o_sat_sticky)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  // Reference reduction straight from the mode definitions, in plain integers.
  task automatic ref_reduce(input logic [1:0] m, input vec_t f, output int val, output bit sat);
    int acc;
    acc = 0;
    if (m == 2'd2) begin
      acc = int'(f[0]);
      for (int i = 1; i < NUM_CH; i++) if (int'(f[i]) > acc) acc = int'(f[i]);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m == 2'd1 && (i % 2) == 1) acc -= int'(f[i]);
        else                           acc += int'(f[i]);
      end
      if (m == 2'd3) acc = acc >>> LVL;
    end
    sat = 1'b0;
    val = acc;
    if (acc > 127)  begin val = 127;  sat = 1'b1; end
    if (acc < -128) begin val = -128; sat = 1'b1; end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check after.
  task automatic tick(input logic v, input logic [1:0] m, input vec_t f,
                      input logic rst, input logic clr);
    int val;
    bit sat;
    bit sat_now;
    i_rst            = rst;
    i_features_valid = v;
    i_mode           = m;
    i_features_in    = f;
    i_sat_clr        = clr;
    @(posedge clk);
    n_edge++;
    sat_now = 1'b0;
    if (rst) begin
      q.delete();
      m_valid  = 0;
      m_out    = 0;
      m_sticky = 0;
    end else begin
      m_valid = 0;
      if (q.size() > 0 && q[0].slot == n_edge) begin
        m_valid = 1;
        m_out   = q[0].val;
        sat_now = q[0].sat;
        void'(q.pop_front());
      end
      m_sticky = ((m_valid == 1 && sat_now) || (m_sticky == 1 && !clr)) ? 1 : 0;
      if (v) begin
        ref_reduce(m, f, val, sat);
        q.push_back('{n_edge + LAT - 1, val, sat});
      end
    end
    @(negedge clk);
    check_eq("valid",  int'(o_feature_valid), m_valid);
    check_eq("out",    int'(o_feature_out),   m_out);
    check_eq("sticky", int'(o_sat_sticky),    m_sticky);
    if (o_feature_valid) begin
      obs_val.push_back(int'(o_feature_out));
      obs_edge.push_back(n_edge);
    end
  endtask

  task automatic rand_vec(output vec_t v);
    for (int i = 0; i < NUM_CH; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i] = 8'sh7f;
        1:       v[i] = 8'sh80;
        default: v[i] = DATA_W'($urandom);
      endcase
    end
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d,
                         input int e, input int g, output vec_t v);
    v[0] = DATA_W'(a); v[1] = DATA_W'(b); v[2] = DATA_W'(c);
    v[3] = DATA_W'(d); v[4] = DATA_W'(e); v[5] = DATA_W'(g);
  endtask

  task automatic idle(input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      rand_vec(v);
      tick(1'b0, 2'($urandom_range(0, 3)), v, 1'b0, 1'b0);
    end
  endtask

  // Single sample, then compare the result LAT cycles later against a spec constant.
  task automatic run_vec(input string tag, input logic [1:0] m, input vec_t v, input int exp);
    tick(1'b1, m, v, 1'b0, 1'b0);
    idle(LAT - 1);
    check_eq({tag, "_valid"}, int'(o_feature_valid), 1);
    check_eq(tag, int'(o_feature_out), exp);
  endtask

  initial begin
    vec_t v;
    vec_t base;
    int   exp_stream [8];

    // Reset with valid traffic streaming in.
    for (int k = 0; k < 2; k++) begin
      rand_vec(v);
      tick(1'b1, 2'($urandom_range(0, 3)), v, 1'b1, 1'b0);
      check_eq("rst_valid",  int'(o_feature_valid), 0);
      check_eq("rst_out",    int'(o_feature_out),   0);
      check_eq("rst_sticky", int'(o_sat_sticky),    0);
    end
    for (int k = 0; k < LAT; k++) begin
      rand_vec(v);
      tick(1'b1, 2'($urandom_range(0, 3)), v, 1'b0, 1'b0);
      if (k < LAT - 1) begin
        check_eq("post_rst_valid",  int'(o_feature_valid), 0);
        check_eq("post_rst_out",    int'(o_feature_out),   0);
        check_eq("post_rst_sticky", int'(o_sat_sticky),    0);
      end
    end
    check_eq("first_after_rst_valid", int'(o_feature_valid), 1);
    idle(LAT + 1);
    tick(1'b0, 2'd0, v, 1'b0, 1'b1);

    // Directed vectors.
    set_vec(1, 2, 3, 4, 5, 6, base);
    run_vec("sum_1to6", 2'd0, base, 21);
    check_eq("sum_1to6_sticky", int'(o_sat_sticky), 0);
    set_vec(100, 100, 100, 100, 100, 100, v);
    run_vec("sum_100", 2'd0, v, 127);
    check_eq("sum_100_sticky", int'(o_sat_sticky), 1);
    set_vec(-128, -128, -128, -128, -128, -128, v);
    run_vec("sum_neg", 2'd0, v, -128);
    run_vec("alt_1to6", 2'd1, base, -3);
    tick(1'b0, 2'd0, v, 1'b0, 1'b1);
    set_vec(127, -128, 127, -128, 127, -128, v);
    run_vec("alt_ext", 2'd1, v, 127);
    check_eq("alt_ext_sticky", int'(o_sat_sticky), 1);
    tick(1'b0, 2'd0, v, 1'b0, 1'b1);
    set_vec(-5, 7, 3, -128, 7, 0, v);
    run_vec("max_mix", 2'd2, v, 7);
    set_vec(-128, -128, -128, -128, -128, -128, v);
    run_vec("max_neg", 2'd2, v, -128);
    check_eq("max_no_sat", int'(o_sat_sticky), 0);
    set_vec(6, 6, 6, 6, 6, 6, v);
    run_vec("mean_6", 2'd3, v, 4);
    set_vec(-1, -1, -1, -1, -1, -1, v);
    run_vec("mean_m1", 2'd3, v, -1);
    set_vec(127, 127, 127, 127, 127, 127, v);
    run_vec("mean_127", 2'd3, v, 95);

    // Back-to-back stream cycling through all modes.
    idle(LAT + 1);
    obs_val.delete();
    obs_edge.delete();
    for (int k = 0; k < 8; k++) tick(1'b1, 2'(k % 4), base, 1'b0, 1'b0);
    idle(LAT + 2);
    exp_stream = '{21, -3, 6, 2, 21, -3, 6, 2};
    check_eq("stream_count", obs_val.size(), 8);
    if (obs_val.size() == 8) begin
      for (int k = 0; k < 8; k++) check_eq("stream_val", obs_val[k], exp_stream[k]);
      check_eq("stream_contig", obs_edge[7] - obs_edge[0], 7);
    end
    check_eq("stream_hold_out",   int'(o_feature_out),   2);
    check_eq("stream_hold_valid", int'(o_feature_valid), 0);

    // Reset drops samples already in flight.
    obs_val.delete();
    for (int k = 0; k < 3; k++) tick(1'b1, 2'd0, base, 1'b0, 1'b0);
    idle(1);
    tick(1'b0, 2'd0, base, 1'b1, 1'b0);
    tick(1'b0, 2'd0, base, 1'b1, 1'b0);
    idle(LAT + 3);
    check_eq("flush_none", obs_val.size(), 0);

    // Clear racing a saturating result, then clear alone.
    set_vec(100, 100, 100, 100, 100, 100, v);
    tick(1'b1, 2'd0, v, 1'b0, 1'b0);
    idle(LAT - 2);
    tick(1'b0, 2'd0, base, 1'b0, 1'b1);
    check_eq("clr_race_valid",  int'(o_feature_valid), 1);
    check_eq("clr_race_sticky", int'(o_sat_sticky),    1);
    tick(1'b0, 2'd0, base, 1'b0, 1'b1);
    check_eq("clr_alone_sticky", int'(o_sat_sticky), 0);

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 3000; k++) begin
      rand_vec(v);
      tick(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), v,
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
